align_tx_framer: RTL and testbench

Transmit-side word framer for the 20-bit PCS link. It generates the training pattern that the receive-side word aligner locks onto, then carries payload words with periodic sync markers. Payload enters through a valid/ready handshake. Output is one 20-bit word per iSclk to the serializer. A compile-time bit-slip injector exists only to exercise the receive aligner in test.

---
 rtl/align_tx_framer.sv | 148 ++++++++++++++
 tb/tb_align_tx_framer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/align_tx_framer.sv
// Transmit word framer: training burst, payload with periodic markers.
// Optional bit-slip injector: ALIGN_TX_SLIP_INJECT_EN.
module align_tx_framer #(
  parameter logic [19:0] TRAIN_WORD  = 20'hFFC00,
  parameter logic [19:0] IDLE_WORD   = 20'hC3C3C,
  parameter int          TRAIN_LEN   = 1024,
  parameter int          SYNC_PERIOD = 4096
) (
  input  logic        iSclk,
  input  logic        iRstN,
  input  logic        iEnable,
  input  logic        iRetrain,
  input  logic        iPeerSync,
  input  logic [19:0] iData,
  input  logic        iValid,
`ifdef ALIGN_TX_SLIP_INJECT_EN
  input  logic [2:0]  iSlip,
`endif
  output logic        oReady,
  output logic [19:0] oD_Link,
  output logic        oTraining
);

  localparam int TW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam int SW = $clog2(SYNC_PERIOD);
  localparam logic [TW-1:0] TMAX = TW'(TRAIN_LEN - 1);
  localparam logic [SW-1:0] SMAX = SW'(SYNC_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_TRAIN, S_DATA, S_MARK
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [TW-1:0] r_train_cnt;
  logic [TW-1:0] w_tcnt;
  logic [SW-1:0] r_sync_cnt;
  logic [SW-1:0] w_scnt;
  logic [19:0]   w_sel;
  logic [19:0]   r_word0;
  logic          w_xfer;

  assign oReady    = (r_state == S_DATA);
  assign oTraining = (r_state == S_TRAIN);
  assign w_xfer    = oReady && iValid;

  // State and counter registers
  always_ff @(posedge iSclk or negedge iRstN) begin
    if (!iRstN) begin
      r_state     <= S_IDLE;
      r_train_cnt <= '0;
      r_sync_cnt  <= '0;
    end else begin
      r_state     <= w_nxt;
      r_train_cnt <= w_tcnt;
      r_sync_cnt  <= w_scnt;
    end
  end

  // Next state, counters and word selection; enable then retrain override
  always_comb begin
    w_nxt  = r_state;
    w_tcnt = r_train_cnt;
    w_scnt = r_sync_cnt;
    w_sel  = '0;
    unique case (r_state)
      S_IDLE: begin
        w_nxt  = S_TRAIN;
        w_tcnt = '0;
        w_scnt = '0;
      end
      S_TRAIN: begin
        w_sel = TRAIN_WORD;
        if (r_train_cnt < TMAX)
          w_tcnt = r_train_cnt + 1'b1;
        if (r_train_cnt >= TMAX && iPeerSync)
          w_nxt = S_DATA;
      end
      S_DATA: begin
        w_sel = w_xfer ? iData : IDLE_WORD;
        if (w_xfer) begin
          if (r_sync_cnt == SMAX) begin
            w_scnt = '0;
            w_nxt  = S_MARK;
          end else begin
            w_scnt = r_sync_cnt + 1'b1;
          end
        end
      end
      S_MARK: begin
        w_sel = TRAIN_WORD;
        w_nxt = S_DATA;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (!iEnable) begin
      w_nxt = S_IDLE;
    end else if (iRetrain &&
                 (r_state == S_DATA ||
                  r_state == S_MARK)) begin
      w_nxt  = S_TRAIN;
      w_tcnt = '0;
      w_scnt = '0;
    end
  end

`ifdef ALIGN_TX_SLIP_INJECT_EN
  logic [19:0] r_word1;
  logic [19:0] w_slip;

  // Splice newer word's low bits over older word's high bits
  always_comb begin
    w_slip = r_word0;
    case (iSlip)
      3'd1: w_slip = {r_word0[18:0], r_word1[19]};
      3'd2: w_slip = {r_word0[17:0], r_word1[19:18]};
      3'd3: w_slip = {r_word0[16:0], r_word1[19:17]};
      3'd4: w_slip = {r_word0[15:0], r_word1[19:16]};
      default: w_slip = r_word0;
    endcase
  end

  // Two-stage output pipeline with slip mux
  always_ff @(posedge iSclk or negedge iRstN) begin
    if (!iRstN) begin
      r_word0 <= '0;
      r_word1 <= '0;
      oD_Link <= '0;
    end else begin
      r_word0 <= w_sel;
      r_word1 <= r_word0;
      oD_Link <= w_slip;
    end
  end
`else
  // Two-stage output pipeline
  always_ff @(posedge iSclk or negedge iRstN) begin
    if (!iRstN) begin
      r_word0 <= '0;
      oD_Link <= '0;
    end else begin
      r_word0 <= w_sel;
      oD_Link <= r_word0;
    end
  end
`endif

endmodule

// File: tb/tb_align_tx_framer.sv
// Randomized bench for align_tx_framer against a behavioural model.
// Build with ALIGN_TX_SLIP_INJECT_EN to exercise the slip injector.
module tb_align_tx_framer;
  localparam logic [19:0] TW = 20'hFFC00;
  localparam logic [19:0] IW = 20'hC3C3C;
  localparam int TL = 8;
  localparam int SP = 4;

  logic clk = 0;
  logic rst_n = 1;
  logic en = 0, retrain = 0, peer = 0, valid = 0;
  logic [19:0] data = 0;
  logic [2:0] slip = 0;
  logic rdy, trn;
  logic [19:0] od;

  int checks = 0;
  int failures = 0;

  align_tx_framer #(
    .TRAIN_LEN(TL), .SYNC_PERIOD(SP)
  ) dut (
    .iSclk(clk), .iRstN(rst_n),
    .iEnable(en), .iRetrain(retrain),
    .iPeerSync(peer), .iData(data),
    .iValid(valid),
`ifdef ALIGN_TX_SLIP_INJECT_EN
    .iSlip(slip),
`endif
    .oReady(rdy), .oD_Link(od),
    .oTraining(trn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [19:0] got,
                     input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Behavioural model: link on/off, words trained so far,
  // pending marker, transfers since last marker.
  bit m_on = 0;
  int m_tr = -1;
  bit m_mark = 0;
  int m_xf = 0;
  logic [19:0] d1 = 0, d2 = 0, e_od = 0;
  bit e_rdy = 0, e_trn = 0;

  function automatic logic [19:0] slipf(
    input logic [19:0] nw, input logic [19:0] ow,
    input int k);
    logic [39:0] cat;
    if (k < 1 || k > 4) return nw;
    cat = {nw, ow};
    cat = cat << k;
    return cat[39:20];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [19:0] sel;
    if (!rst_n) begin
      m_on = 0; m_tr = -1; m_mark = 0; m_xf = 0;
      d1 = 0; d2 = 0; e_od = 0;
      e_rdy = 0; e_trn = 0;
    end else begin
      if (!m_on) sel = 0;
      else if (m_tr >= 0 || m_mark) sel = TW;
      else sel = valid ? data : IW;
`ifdef ALIGN_TX_SLIP_INJECT_EN
      e_od = slipf(d1, d2, int'(slip));
`else
      e_od = d1;
`endif
      d2 = d1;
      d1 = sel;
      if (!en) begin
        m_on = 0; m_tr = -1; m_mark = 0;
      end else if (!m_on) begin
        m_on = 1; m_tr = 0; m_xf = 0;
      end else if (m_tr >= 0) begin
        m_tr++;
        if (m_tr >= TL && peer) m_tr = -1;
      end else if (retrain) begin
        m_tr = 0; m_mark = 0; m_xf = 0;
      end else if (m_mark) begin
        m_mark = 0;
      end else if (valid) begin
        m_xf++;
        if (m_xf == SP) begin
          m_xf = 0; m_mark = 1;
        end
      end
      e_rdy = m_on && m_tr < 0 && !m_mark;
      e_trn = m_tr >= 0;
    end
  end

  // Per-cycle compare
  always @(negedge clk) begin
    chk("od", od, e_od);
    chk("ready", 20'(rdy), 20'(e_rdy));
    chk("training", 20'(trn), 20'(e_trn));
  end

  // Training-run length and non-idle word log
  int run = 0, last_run = 0;
  bit rec = 0;
  logic [19:0] q[$];
  always @(negedge clk) begin
    if (od == TW) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
    if (rec && od != IW) q.push_back(od);
  end

  bit took = 0;
  always @(posedge clk) took <= valid && rdy;

  bit seqmode = 0;
  logic [19:0] seqv = 1;

  task automatic step();
    @(negedge clk);
    #1;
    if (took) begin
      if (seqmode) begin
        seqv = seqv + 1;
        data = seqv;
      end else begin
        data = 20'($urandom);
      end
    end
  endtask

  initial begin
    logic [19:0] expq[10];
    logic [19:0] g;
    expq = '{20'h1, 20'h2, 20'h3, 20'h4, TW,
             20'h5, 20'h6, 20'h7, 20'h8, TW};
    #1 rst_n = 0;
    repeat (5) begin
      step();
      en = 1'($urandom); valid = 1'($urandom);
      peer = 1'($urandom); retrain = 1'($urandom);
      data = 20'($urandom);
    end
    chk("reset_od", od, 20'h0);
    chk("reset_rdy", 20'(rdy), 20'h0);
    step();
    en = 0; retrain = 0; valid = 0; peer = 0;
    rst_n = 1;
    repeat (5) step();
    chk("idle_od", od, 20'h0);
    en = 1; peer = 1;
    repeat (15) step();
    chk("train_len", 20'(last_run), 20'd8);
    peer = 0; retrain = 1;
    @(posedge clk);
    @(negedge clk); #1 retrain = 0;
    repeat (19) @(posedge clk);
    @(negedge clk); #1 peer = 1;
    repeat (6) step();
    chk("late_lock_len", 20'(last_run), 20'd20);
    seqmode = 1; rec = 1;
    seqv = 1; data = 1; valid = 1;
    repeat (16) step();
    valid = 0;
    repeat (4) step();
    rec = 0;
    for (int i = 0; i < 10; i++) begin
      g = (i < q.size()) ? q[i] : 20'hDEAD0;
      chk($sformatf("marker_seq%0d", i), g, expq[i]);
    end
    seqmode = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      valid = ($urandom % 4) != 0;
      peer = ($urandom % 8) != 0;
      retrain = ($urandom % 40) == 0;
      en = ($urandom % 200) != 0;
      slip = 3'($urandom);
      if (c == 1500) begin
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1;
      end
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
